// File: rtl/ser_engine_if.sv
// Command, status and serial-pin bundle between the eCPU command decode and ser_engine.
interface ser_engine_if #(
  parameter int NCH      = 3,
  parameter int MAX_BITS = 32,
  parameter int DIV_W    = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NB_W = $clog2(MAX_BITS + 1);

  logic                start;
  logic [CH_W-1:0]     chan;
  logic [NB_W-1:0]     nbits;
  logic [DIV_W-1:0]    div;
  logic [MAX_BITS-1:0] wdata;
  logic                abort;
  logic                ovr_clr;
  logic                busy;
  logic                done;
  logic                ovr;
  logic [MAX_BITS-1:0] rdata;
  logic [NCH-1:0]      sclk;
  logic [NCH-1:0]      sdo;
  logic [NCH-1:0]      cs;
  logic [NCH-1:0]      sdi;

  modport master (
    output start, chan, nbits, div, wdata, abort, ovr_clr, sdi,
    input  busy, done, ovr, rdata, sclk, sdo, cs
  );

  modport slave (
    input  start, chan, nbits, div, wdata, abort, ovr_clr, sdi,
    output busy, done, ovr, rdata, sclk, sdo, cs
  );
endinterface

// File: rtl/ser_engine.sv
// Serial shift engine: shifts a word MSB-first out of one select-addressed channel
// with a programmable half-period, capturing read-back bits from that channel's sdi.
module ser_engine #(
  parameter int             NCH        = 3,
  parameter int             MAX_BITS   = 32,
  parameter int             DIV_W      = 8,
  parameter logic [NCH-1:0] CS_ACT_LOW = 3'b010
) (
  input logic         clk,
  input logic         rst,
  ser_engine_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NB_W = $clog2(MAX_BITS + 1);
  localparam logic [NB_W-1:0] MAX_N = NB_W'(MAX_BITS);
  localparam logic [NB_W-1:0] ONE_N = NB_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state, w_seq, w_next;
  logic [DIV_W-1:0]    r_cnt, r_div;
  logic [CH_W-1:0]     r_chan, w_nxt_chan;
  logic [NB_W-1:0]     r_left, w_n, w_align;
  logic [MAX_BITS-1:0] r_shift, w_shift_nxt, r_rdata;
  logic                r_ovr, r_busy, r_done;
  logic [NCH-1:0]      r_sclk, r_sdo, r_cs, w_sel, w_sclk, w_sdo, w_cs;
  logic                w_active, w_nxt_active, w_accept, w_cnt_zero;
  logic                w_enter_high, w_leave_high, w_sdi_bit;

  assign w_n          = (bus.nbits > MAX_N) ? MAX_N : bus.nbits;
  assign w_align      = MAX_N - w_n;
  assign w_active     = (r_state == S_SETUP) || (r_state == S_HIGH) ||
                        (r_state == S_LOW)   || (r_state == S_HOLD);
  assign w_accept     = (r_state == S_IDLE) && bus.start;
  assign w_cnt_zero   = (r_cnt == {DIV_W{1'b0}});
  assign w_enter_high = (w_next == S_HIGH) && (r_state != S_HIGH);
  assign w_leave_high = (r_state == S_HIGH) && (w_next != S_HIGH);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: each timed phase ends when the down-counter reaches zero; abort overrides
  always_comb begin
    w_seq = r_state;
    case (r_state)
      S_IDLE:  w_seq = bus.start ? ((w_n == {NB_W{1'b0}}) ? S_DONE : S_SETUP) : S_IDLE;
      S_SETUP: w_seq = w_cnt_zero ? S_HIGH : S_SETUP;
      S_HIGH:  w_seq = w_cnt_zero ? ((r_left == ONE_N) ? S_HOLD : S_LOW) : S_HIGH;
      S_LOW:   w_seq = w_cnt_zero ? S_HIGH : S_LOW;
      S_HOLD:  w_seq = w_cnt_zero ? S_DONE : S_HOLD;
      S_DONE:  w_seq = S_IDLE;
      default: w_seq = S_IDLE;
    endcase
    w_next = (bus.abort && w_active) ? S_IDLE : w_seq;
  end

  // Next shift-register value: aligned load on accept, advance only when HIGH hands over to LOW
  always_comb begin
    if (w_accept)                              w_shift_nxt = bus.wdata << w_align;
    else if (w_leave_high && w_next == S_LOW)  w_shift_nxt = r_shift << 1;
    else                                       w_shift_nxt = r_shift;
  end

  // Outputs: pin values for the upcoming state, so the pins toggle straight from flops
  always_comb begin
    w_nxt_active = (w_next == S_SETUP) || (w_next == S_HIGH) ||
                   (w_next == S_LOW)   || (w_next == S_HOLD);
    w_nxt_chan   = w_accept ? bus.chan : r_chan;
    for (int i = 0; i < NCH; i++) begin
      w_sel[i]  = w_nxt_active && (w_nxt_chan == CH_W'(i));
      w_sclk[i] = w_sel[i] && (w_next == S_HIGH);
      w_sdo[i]  = w_sel[i] && w_shift_nxt[MAX_BITS-1];
      w_cs[i]   = CS_ACT_LOW[i] ^ w_sel[i];
    end
  end

  // Read-back bit from the latched channel; out-of-range channels read as zero
  always_comb begin
    w_sdi_bit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_sdi_bit = w_sdi_bit | ((r_chan == CH_W'(i)) & bus.sdi[i]);
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sclk <= {NCH{1'b0}};
      r_sdo  <= {NCH{1'b0}};
      r_cs   <= CS_ACT_LOW;
    end else begin
      r_busy <= w_nxt_active;
      r_done <= (w_next == S_DONE);
      r_sclk <= w_sclk;
      r_sdo  <= w_sdo;
      r_cs   <= w_cs;
    end
  end

  // Phase timer, command latch, shift and bit-count datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= {DIV_W{1'b0}};
      r_div   <= {DIV_W{1'b0}};
      r_chan  <= {CH_W{1'b0}};
      r_left  <= {NB_W{1'b0}};
      r_shift <= {MAX_BITS{1'b0}};
    end else begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_cnt  <= bus.div;
        r_div  <= bus.div;
        r_chan <= bus.chan;
        r_left <= w_n;
      end else if (w_next != r_state) begin
        r_cnt <= r_div;
        if (w_leave_high) r_left <= r_left - ONE_N;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read-back capture (cleared on accept) and sticky overrun flag; a new overrun beats clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= {MAX_BITS{1'b0}};
      r_ovr   <= 1'b0;
    end else begin
      if (w_accept)          r_rdata <= {MAX_BITS{1'b0}};
      else if (w_enter_high) r_rdata <= {r_rdata[MAX_BITS-2:0], w_sdi_bit};
      if (bus.start && r_state != S_IDLE) r_ovr <= 1'b1;
      else if (bus.ovr_clr)               r_ovr <= 1'b0;
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.ovr   = r_ovr;
  assign bus.rdata = r_rdata;
  assign bus.sclk  = r_sclk;
  assign bus.sdo   = r_sdo;
  assign bus.cs    = r_cs;
endmodule

// File: tb/tb_ser_engine.sv
// Randomised self-checking bench for ser_engine; sdi is looped back from sdo with a
// per-channel inversion mask so read-back values follow directly from the transmit word.
module tb_ser_engine;
  localparam int NCH = 3;
  localparam int MAX_BITS = 32;
  localparam int DIV_W = 8;
  localparam logic [2:0] CS_ACT_LOW = 3'b010;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] inv = 3'b000;
  int n_pass = 0;
  int n_total = 0;

  ser_engine_if #(.NCH(NCH), .MAX_BITS(MAX_BITS), .DIV_W(DIV_W)) bus ();

  ser_engine #(.NCH(NCH), .MAX_BITS(MAX_BITS), .DIV_W(DIV_W), .CS_ACT_LOW(CS_ACT_LOW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.sdi = bus.sdo ^ inv;

  always #5 clk = ~clk;

  function automatic int eff_n(input int nb);
    return (nb > MAX_BITS) ? MAX_BITS : nb;
  endfunction

  function automatic int exp_lat(input int n, input int d);
    return (n == 0) ? 1 : (2 * n + 1) * (d + 1) + 1;
  endfunction

  function automatic logic [31:0] nmask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Issue one command and watch the pins until done or the cycle budget runs out.
  // inj_kind: 1 = extra start at inj_at, 2 = extra start + ovr_clr, 3 = abort.
  task automatic xfer(input int ch, input int nb, input int dv, input logic [31:0] wd,
                      input int inj_at, input int inj_kind, input int budget,
                      output int lat, output logic [31:0] seen, output int nseen,
                      output int cs_cyc, output int stray);
    logic prev;
    int   chv;
    int   nbv;
    int   dvv;
    chv = ch; nbv = nb; dvv = dv;
    @(negedge clk);
    bus.start = 1'b1; bus.chan = chv[1:0]; bus.nbits = nbv[5:0]; bus.div = dvv[7:0]; bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; seen = 32'd0; nseen = 0; cs_cyc = 0; stray = 0; prev = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      bus.start = 1'b0; bus.ovr_clr = 1'b0; bus.abort = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (i == ch) begin
          if (bus.cs[i] != CS_ACT_LOW[i]) cs_cyc++;
          if (bus.sclk[i] && !prev) begin
            seen = {seen[30:0], bus.sdo[i]};
            nseen++;
          end
          prev = bus.sclk[i];
        end else if (bus.sclk[i] || bus.sdo[i] || (bus.cs[i] != CS_ACT_LOW[i])) begin
          stray++;
        end
      end
      if (bus.done) begin
        lat = c;
        break;
      end
      if (c == inj_at) begin
        if (inj_kind == 1 || inj_kind == 2) begin
          bus.start = 1'b1; bus.chan = 2'd2; bus.nbits = 6'd5; bus.wdata = ~wd;
        end
        if (inj_kind == 2) bus.ovr_clr = 1'b1;
        if (inj_kind == 3) bus.abort = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.ovr_clr = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    int done_cnt;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", bus.ovr); else n_pass++;
    n_total++; if (bus.rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else n_pass++;
    n_total++; if (bus.sclk !== 3'b000 || bus.sdo !== 3'b000) $display("FAIL reset_pins: sclk %b sdo %b want 000", bus.sclk, bus.sdo); else n_pass++;
    n_total++; if (bus.cs !== CS_ACT_LOW) $display("FAIL reset_cs: got %b want %b", bus.cs, CS_ACT_LOW); else n_pass++;
    rst = 1'b1;
    // reset mid-transfer: chan 1, 8 bits, div 3, reset asserted during cycle 10
    @(negedge clk);
    bus.start = 1'b1; bus.chan = 2'd1; bus.nbits = 6'd8; bus.div = 8'd3; bus.wdata = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL midrst_active: busy got %b want 1", bus.busy); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.cs !== CS_ACT_LOW || bus.sclk !== 3'b000) $display("FAIL midrst_pins: cs %b sclk %b want %b 000", bus.cs, bus.sclk, CS_ACT_LOW); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL midrst_status: busy %b done %b want 0 0", bus.busy, bus.done); else n_pass++;
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_total++; if (done_cnt !== 0) $display("FAIL midrst_nodone: got %0d done pulses want 0", done_cnt); else n_pass++;
  endtask

  task automatic test_basic_write();
    int lat, nseen, cs_cyc, stray;
    logic [31:0] seen;
    inv = 3'b000;
    xfer(0, 4, 1, 32'h0000000A, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== 19) $display("FAIL basic_lat: got %0d want 19", lat); else n_pass++;
    n_total++; if (seen !== 32'hA || nseen !== 4) $display("FAIL basic_sdo: got %h/%0d bits want a/4", seen, nseen); else n_pass++;
    n_total++; if (cs_cyc !== 18) $display("FAIL basic_cs: got %0d cycles want 18", cs_cyc); else n_pass++;
    n_total++; if (stray !== 0) $display("FAIL basic_stray: got %0d want 0", stray); else n_pass++;
    n_total++; if (bus.rdata !== 32'hA) $display("FAIL basic_rdata: got %h want a", bus.rdata); else n_pass++;
  endtask

  task automatic test_loopback();
    int lat, nseen, cs_cyc, stray;
    logic [31:0] seen;
    inv = 3'b000;
    xfer(2, 32, 0, 32'hDEADBEEF, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== 66) $display("FAIL loop_lat: got %0d want 66", lat); else n_pass++;
    n_total++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL loop_rdata: got %h want deadbeef", bus.rdata); else n_pass++;
    n_total++; if (cs_cyc !== 65) $display("FAIL loop_cs: got %0d active-high cycles want 65", cs_cyc); else n_pass++;
    n_total++; if (seen !== 32'hDEADBEEF || stray !== 0) $display("FAIL loop_sdo: got %h stray %0d want deadbeef 0", seen, stray); else n_pass++;
  endtask

  task automatic test_overrun();
    int lat, nseen, cs_cyc, stray;
    logic [31:0] seen, wd;
    inv = 3'b001;
    wd = $urandom;
    xfer(0, 8, 1, wd, 5, 1, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== exp_lat(8, 1)) $display("FAIL ovr_lat: got %0d want %0d", lat, exp_lat(8, 1)); else n_pass++;
    n_total++; if (seen !== (wd & nmask(8))) $display("FAIL ovr_sdo: got %h want %h", seen, wd & nmask(8)); else n_pass++;
    n_total++; if (bus.rdata !== (~wd & nmask(8))) $display("FAIL ovr_rdata: got %h want %h", bus.rdata, ~wd & nmask(8)); else n_pass++;
    n_total++; if (bus.ovr !== 1'b1) $display("FAIL ovr_set: got %b want 1", bus.ovr); else n_pass++;
    @(negedge clk); bus.ovr_clr = 1'b1;
    @(negedge clk); bus.ovr_clr = 1'b0;
    n_total++; if (bus.ovr !== 1'b0) $display("FAIL ovr_clr: got %b want 0", bus.ovr); else n_pass++;
    wd = $urandom;
    xfer(1, 6, 0, wd, 3, 2, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (bus.ovr !== 1'b1) $display("FAIL ovr_set_wins: got %b want 1", bus.ovr); else n_pass++;
    n_total++; if (lat !== exp_lat(6, 0)) $display("FAIL ovr_lat2: got %0d want %0d", lat, exp_lat(6, 0)); else n_pass++;
    @(negedge clk); bus.ovr_clr = 1'b1;
    @(negedge clk); bus.ovr_clr = 1'b0;
    inv = 3'b000;
  endtask

  task automatic test_abort();
    int lat, nseen, cs_cyc, stray, k;
    logic [31:0] seen, wd, exp_r;
    inv = 3'b010;
    wd = $urandom;
    xfer(1, 16, 2, wd, 20, 3, 20, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== -1) $display("FAIL abort_nodone: done seen at cycle %0d want none", lat); else n_pass++;
    n_total++; if (bus.cs !== CS_ACT_LOW || bus.sclk !== 3'b000 || bus.sdo !== 3'b000) $display("FAIL abort_pins: cs %b sclk %b sdo %b", bus.cs, bus.sclk, bus.sdo); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_status: busy %b done %b want 0 0", bus.busy, bus.done); else n_pass++;
    k = 0;
    for (int i = 0; i < 16; i++) if ((2 * i + 1) * 3 + 1 <= 20) k++;
    exp_r = (~wd & nmask(16)) >> (16 - k);
    n_total++; if (bus.rdata !== exp_r) $display("FAIL abort_partial: got %h want %h", bus.rdata, exp_r); else n_pass++;
    inv = 3'b000;
    wd = $urandom;
    xfer(0, 3, 0, wd, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== exp_lat(3, 0) || bus.rdata !== (wd & nmask(3))) $display("FAIL abort_restart: lat %0d rdata %h want %0d %h", lat, bus.rdata, exp_lat(3, 0), wd & nmask(3)); else n_pass++;
  endtask

  task automatic test_boundaries();
    int lat, nseen, cs_cyc, stray;
    logic [31:0] seen, wd;
    inv = 3'b000;
    wd = $urandom;
    xfer(1, 0, 3, wd, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== 1) $display("FAIL zero_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (cs_cyc !== 0 || nseen !== 0 || stray !== 0) $display("FAIL zero_pins: cs %0d edges %0d stray %0d want 0", cs_cyc, nseen, stray); else n_pass++;
    n_total++; if (bus.rdata !== 32'd0) $display("FAIL zero_rdata: got %h want 0", bus.rdata); else n_pass++;
    wd = $urandom;
    xfer(0, 40, 0, wd, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== 66 || nseen !== 32) $display("FAIL clamp: lat %0d edges %0d want 66 32", lat, nseen); else n_pass++;
    n_total++; if (seen !== wd || bus.rdata !== wd) $display("FAIL clamp_data: sdo %h rdata %h want %h", seen, bus.rdata, wd); else n_pass++;
    inv = 3'b111;
    xfer(3, 5, 1, wd, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
    n_total++; if (lat !== exp_lat(5, 1)) $display("FAIL badch_lat: got %0d want %0d", lat, exp_lat(5, 1)); else n_pass++;
    n_total++; if (stray !== 0 || bus.rdata !== 32'd0) $display("FAIL badch_quiet: stray %0d rdata %h want 0 0", stray, bus.rdata); else n_pass++;
    inv = 3'b000;
  endtask

  task automatic test_random();
    int lat, nseen, cs_cyc, stray, ch, nb, dv, n;
    logic [31:0] seen, wd, exp_r, exp_s;
    for (int it = 0; it < 12; it++) begin
      ch = $urandom_range(0, 3);
      nb = $urandom_range(0, 40);
      dv = $urandom_range(0, 3);
      wd = $urandom;
      inv = 3'($urandom_range(0, 7));
      n = eff_n(nb);
      xfer(ch, nb, dv, wd, 0, 0, BUDGET, lat, seen, nseen, cs_cyc, stray);
      if (ch < NCH) begin
        exp_r = (wd ^ {32{inv[ch]}}) & nmask(n);
        exp_s = wd & nmask(n);
      end else begin
        exp_r = 32'd0;
        exp_s = 32'd0;
      end
      n_total++; if (lat !== exp_lat(n, dv)) $display("FAIL rand%0d_lat: got %0d want %0d", it, lat, exp_lat(n, dv)); else n_pass++;
      n_total++; if (bus.rdata !== exp_r) $display("FAIL rand%0d_rdata: got %h want %h", it, bus.rdata, exp_r); else n_pass++;
      n_total++; if (seen !== exp_s) $display("FAIL rand%0d_sdo: got %h want %h", it, seen, exp_s); else n_pass++;
      n_total++; if (stray !== 0) $display("FAIL rand%0d_stray: got %0d want 0", it, stray); else n_pass++;
    end
    inv = 3'b000;
  endtask

  initial begin
    bus.start = 1'b0; bus.chan = 2'd0; bus.nbits = 6'd0; bus.div = 8'd0;
    bus.wdata = 32'd0; bus.abort = 1'b0; bus.ovr_clr = 1'b0;
    test_reset();
    test_basic_write();
    test_loopback();
    test_overrun();
    test_abort();
    test_boundaries();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
